// File: rtl/hkspi_slave_core.sv
// Housekeeping SPI slave front end: oversamples the SPI pins on the core
// clock, deserializes command/address/data bytes onto an 8-bit register
// port, shifts read data out on SDO and raises the flash pass-thru flags.
module hkspi_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csb,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       pass_thru_mgmt,
    output logic       pass_thru_user,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, DONE, PASSTHRU} state_t;

    localparam logic [7:0] CMD_PT_MGMT = 8'hC4;
    localparam logic [7:0] CMD_PT_USER = 8'hC2;

    logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync;
    logic                   sck_q, csb_q;
    logic                   sck_s, csb_s, sdi_s;
    logic                   sck_rise, sck_fall, csb_rise;

    state_t     state;
    logic       armed;      // CSB has been seen high since reset
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] in_byte;
    logic       wr_mode, rd_mode;
    logic [2:0] byte_num;   // 0 = stream
    logic [2:0] byte_cnt;
    logic       last_byte;
    logic [7:0] tx_buf;
    logic [6:0] tx_shift;
    logic       rd_cap;     // reg_rdata is valid this cycle
    logic       inc_pend;   // bump reg_addr after a completed data byte
    logic       re_pend;    // prefetch at the bumped address

    // Pin synchronizers plus edge register; unreset so they always track the pins
    always_ff @(posedge clk) begin
        sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
        csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
        sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
        sck_q    <= sck_s;
        csb_q    <= csb_s;
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_q;
    assign sck_fall  = ~sck_s & sck_q;
    assign csb_rise  = csb_s & ~csb_q;
    assign in_byte   = {shift_in, sdi_s};
    assign last_byte = (byte_num != 3'd0) && ((byte_cnt + 3'd1) == byte_num);

    // Transaction FSM with register-port strobes and the SDO shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b0;
            bit_cnt        <= '0;
            shift_in       <= '0;
            wr_mode        <= 1'b0;
            rd_mode        <= 1'b0;
            byte_num       <= '0;
            byte_cnt       <= '0;
            tx_buf         <= '0;
            tx_shift       <= '0;
            rd_cap         <= 1'b0;
            inc_pend       <= 1'b0;
            re_pend        <= 1'b0;
            spi_sdo        <= 1'b0;
            spi_sdo_oe     <= 1'b0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
            reg_we         <= 1'b0;
            reg_re         <= 1'b0;
            pass_thru_mgmt <= 1'b0;
            pass_thru_user <= 1'b0;
            busy           <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            inc_pend <= 1'b0;
            rd_cap   <= reg_re;
            if (rd_cap) tx_buf <= reg_rdata;
            // A completed byte always finishes its address bump, even across CSB high
            if (inc_pend) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= re_pend;
            end
            if (csb_s) armed <= 1'b1;
            busy       <= armed & ~csb_s;
            spi_sdo_oe <= (state == DATA) & rd_mode;
            if (state != DATA) spi_sdo <= 1'b0;

            if (csb_rise) begin
                state          <= IDLE;
                bit_cnt        <= '0;
                pass_thru_mgmt <= 1'b0;
                pass_thru_user <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (armed && !csb_s) begin
                        state   <= COMMAND;
                        bit_cnt <= '0;
                    end
                    COMMAND: if (sck_rise) begin
                        shift_in <= in_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (in_byte == CMD_PT_MGMT) begin
                                state          <= PASSTHRU;
                                pass_thru_mgmt <= 1'b1;
                            end else if (in_byte == CMD_PT_USER) begin
                                state          <= PASSTHRU;
                                pass_thru_user <= 1'b1;
                            end else if (in_byte[7:6] == 2'b00) begin
                                state <= DONE;
                            end else begin
                                wr_mode  <= in_byte[7];
                                rd_mode  <= in_byte[6];
                                byte_num <= in_byte[5:3];
                                state    <= ADDRESS;
                            end
                        end
                    end
                    ADDRESS: if (sck_rise) begin
                        shift_in <= in_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            reg_addr <= in_byte;
                            reg_re   <= rd_mode;
                            byte_cnt <= '0;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        // Byte boundary reloads from the prefetched buffer
                        if (sck_fall) begin
                            if (bit_cnt == 3'd0) begin
                                spi_sdo  <= tx_buf[7];
                                tx_shift <= tx_buf[6:0];
                            end else begin
                                spi_sdo  <= tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                        if (sck_rise) begin
                            shift_in <= in_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                reg_wdata <= in_byte;
                                reg_we    <= wr_mode;
                                inc_pend  <= 1'b1;
                                re_pend   <= rd_mode & ~last_byte;
                                byte_cnt  <= byte_cnt + 3'd1;
                                if (last_byte) state <= DONE;
                            end
                        end
                    end
                    DONE, PASSTHRU: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hkspi_slave_core.sv
// Directed bench for hkspi_slave_core: table of SPI transactions plus
// hand-written pass-thru, abort and mid-transaction reset sequences.
module tb_hkspi_slave_core;
    localparam int HALF = 6;   // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0, spi_csb = 1'b1, spi_sdi = 1'b0;
    logic       spi_sdo, spi_sdo_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re;
    logic       pass_thru_mgmt, pass_thru_user, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] we_addr[$], we_data[$], re_addr[$];

    hkspi_slave_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_sck(spi_sck), .spi_csb(spi_csb), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .pass_thru_mgmt(pass_thru_mgmt), .pass_thru_user(pass_thru_user),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file model: read data one cycle after reg_re
    always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (reg_we) begin
            we_addr.push_back(reg_addr);
            we_data.push_back(reg_wdata);
        end
        if (reg_re) re_addr.push_back(reg_addr);
    end

    typedef struct {
        logic [7:0] cmd, addr, d0, d1;
        int         nb;                    // data bytes clocked
        bit         chk_rx;
        logic [7:0] rx0, rx1;
        int         n_we;
        logic [7:0] we_a0, we_d0, we_a1, we_d1;
        int         n_re;
        logic [7:0] re_a0, re_a1;
        int         oe0, oe1;              // bit samples with oe=1 per data byte
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        we_addr.delete(); we_data.delete(); re_addr.delete();
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output int oe_n);
        rx = '0; oe_n = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sdi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = spi_sdo;
            if (spi_sdo_oe) oe_n++;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic csb_lo();
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic csb_hi();
        repeat (HALF) @(negedge clk);
        spi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic read03(input string nm);
        logic [7:0] rx;
        int oe;
        clear_mon();
        csb_lo();
        spi_bits(8'h40, 8, rx, oe);
        spi_bits(8'h03, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        csb_hi();
        check({nm, "_rx"}, int'(rx), 8'h11);
        check({nm, "_re_addr"}, re_addr.size() > 0 ? int'(re_addr[0]) : -1, 8'h03);
        check({nm, "_we_cnt"}, we_addr.size(), 0);
    endtask

    task automatic pt_seq(input logic [7:0] cmd, input bit mgmt, input string nm);
        logic [7:0] rx;
        int oe, oe_tot;
        clear_mon();
        oe_tot = 0;
        csb_lo();
        spi_bits(cmd, 7, rx, oe);
        spi_sdi = cmd[0];
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b1;
        repeat (2) @(negedge clk);
        check({nm, "_pre"}, mgmt ? pass_thru_mgmt : pass_thru_user, 0);
        @(negedge clk);
        check({nm, "_set"}, mgmt ? pass_thru_mgmt : pass_thru_user, 1);
        check({nm, "_other"}, mgmt ? pass_thru_user : pass_thru_mgmt, 0);
        repeat (HALF - 3) @(negedge clk);
        spi_sck = 1'b0;
        for (int b = 0; b < 5; b++) begin
            spi_bits(8'h5A, 8, rx, oe);
            oe_tot += oe;
        end
        check({nm, "_oe"}, oe_tot, 0);
        check({nm, "_we_cnt"}, we_addr.size(), 0);
        check({nm, "_re_cnt"}, re_addr.size(), 0);
        check({nm, "_held"}, mgmt ? pass_thru_mgmt : pass_thru_user, 1);
        repeat (HALF) @(negedge clk);
        spi_csb = 1'b1;
        repeat (2) @(negedge clk);
        check({nm, "_hold_csb"}, mgmt ? pass_thru_mgmt : pass_thru_user, 1);
        @(negedge clk);
        check({nm, "_clr"}, mgmt ? pass_thru_mgmt : pass_thru_user, 0);
        repeat (2 * HALF) @(negedge clk);
    endtask

    vec_t vec [6];

    initial begin
        logic [7:0] rx0, rx1, rx;
        int oe_a, oe_b, oe0, oe1;

        // Field order: cmd addr d0 d1 nb chk_rx rx0 rx1 n_we we_a0 we_d0 we_a1 we_d1 n_re re_a0 re_a1 oe0 oe1
        vec[0] = '{8'h40, 8'h03, 8'h00, 8'h00, 1, 1'b1, 8'h11, 8'h00,
                   0, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h03, 8'h04, 8, 0};
        vec[1] = '{8'h80, 8'h10, 8'hA5, 8'h5A, 2, 1'b0, 8'h00, 8'h00,
                   2, 8'h10, 8'hA5, 8'h11, 8'h5A, 0, 8'h00, 8'h00, 0, 0};
        vec[2] = '{8'h48, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 8'h3C, 8'h00,
                   0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 8, 0};
        vec[3] = '{8'hC8, 8'h20, 8'h77, 8'h00, 2, 1'b1, 8'h9E, 8'h00,
                   1, 8'h20, 8'h77, 8'h00, 8'h00, 1, 8'h20, 8'h00, 8, 0};
        vec[4] = '{8'h00, 8'h55, 8'hAA, 8'h00, 2, 1'b1, 8'h00, 8'h00,
                   0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0};
        vec[5] = '{8'h40, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 8'h3C, 8'h5D,
                   0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'hFF, 8'h00, 8, 8};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h03] = 8'h11; mem[8'h04] = 8'h22; mem[8'hFF] = 8'h3C;
        mem[8'h00] = 8'h5D; mem[8'h20] = 8'h9E;

        repeat (5) @(negedge clk);
        check("rst_sdo", spi_sdo, 0);
        check("rst_oe", spi_sdo_oe, 0);
        check("rst_addr", int'(reg_addr), 0);
        check("rst_we_re", {reg_we, reg_re}, 0);
        check("rst_pt", {pass_thru_mgmt, pass_thru_user}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            clear_mon();
            csb_lo();
            check($sformatf("v%0d_busy", k), busy, 1);
            spi_bits(vec[k].cmd, 8, rx, oe_a);
            spi_bits(vec[k].addr, 8, rx, oe_b);
            check($sformatf("v%0d_hdr_oe", k), oe_a + oe_b, 0);
            spi_bits(vec[k].d0, 8, rx0, oe0);
            if (vec[k].nb > 1) spi_bits(vec[k].d1, 8, rx1, oe1);
            csb_hi();
            check($sformatf("v%0d_oe0", k), oe0, vec[k].oe0);
            if (vec[k].chk_rx) check($sformatf("v%0d_rx0", k), int'(rx0), int'(vec[k].rx0));
            if (vec[k].nb > 1) begin
                check($sformatf("v%0d_oe1", k), oe1, vec[k].oe1);
                if (vec[k].chk_rx) check($sformatf("v%0d_rx1", k), int'(rx1), int'(vec[k].rx1));
            end
            check($sformatf("v%0d_we_cnt", k), we_addr.size(), vec[k].n_we);
            if (vec[k].n_we > 0 && we_addr.size() > 0) begin
                check($sformatf("v%0d_we0_addr", k), int'(we_addr[0]), int'(vec[k].we_a0));
                check($sformatf("v%0d_we0_data", k), int'(we_data[0]), int'(vec[k].we_d0));
            end
            if (vec[k].n_we > 1 && we_addr.size() > 1) begin
                check($sformatf("v%0d_we1_addr", k), int'(we_addr[1]), int'(vec[k].we_a1));
                check($sformatf("v%0d_we1_data", k), int'(we_data[1]), int'(vec[k].we_d1));
            end
            check($sformatf("v%0d_re_cnt", k), re_addr.size(), vec[k].n_re);
            if (vec[k].n_re > 0 && re_addr.size() > 0)
                check($sformatf("v%0d_re0_addr", k), int'(re_addr[0]), int'(vec[k].re_a0));
            if (vec[k].n_re > 1 && re_addr.size() > 1)
                check($sformatf("v%0d_re1_addr", k), int'(re_addr[1]), int'(vec[k].re_a1));
            check($sformatf("v%0d_busy_end", k), busy, 0);
        end

        pt_seq(8'hC4, 1'b1, "pt_mgmt");
        pt_seq(8'hC2, 1'b0, "pt_user");

        // Abort a write after 5 data bits
        clear_mon();
        csb_lo();
        spi_bits(8'h80, 8, rx, oe_a);
        spi_bits(8'h30, 8, rx, oe_a);
        spi_bits(8'hFF, 5, rx, oe_a);
        csb_hi();
        check("abort_we_cnt", we_addr.size(), 0);
        check("abort_re_cnt", re_addr.size(), 0);
        read03("abort_rd");

        // Reset pulse in the middle of a read data byte
        clear_mon();
        csb_lo();
        spi_bits(8'h40, 8, rx, oe_a);
        spi_bits(8'h03, 8, rx, oe_a);
        spi_bits(8'h00, 3, rx, oe_a);
        check("mid_oe", spi_sdo_oe, 1);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_sdo", spi_sdo, 0);
        check("mrst_oe", spi_sdo_oe, 0);
        check("mrst_addr", int'(reg_addr), 0);
        check("mrst_wdata", int'(reg_wdata), 0);
        check("mrst_we_re", {reg_we, reg_re}, 0);
        check("mrst_pt", {pass_thru_mgmt, pass_thru_user}, 0);
        check("mrst_busy", busy, 0);
        clear_mon();
        spi_bits(8'h40, 8, rx, oe_a);
        spi_bits(8'h03, 8, rx, oe_b);
        check("mrst_idle_oe", oe_a + oe_b, 0);
        check("mrst_idle_re", re_addr.size(), 0);
        check("mrst_idle_busy", busy, 0);
        csb_hi();
        read03("mrst_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
